store_buffer: RTL and testbench

Store-side counterpart of the load alignment path: accepts RV32I stores (sb/sh/sw) from the MEM stage, replicates write data into byte lanes, and generates the 4-bit byte-enable mask. Aligned stores go into a small in-order FIFO that drains to the data-cache port with a write/response handshake. The block flags misaligned or illegal stores and reports load-address hazards against pending entries, so the pipeline can stall dependent loads.

---
 rtl/rv32i_types.sv | 19 +
 rtl/store_aligner.sv | 37 +++
 rtl/store_buffer.sv | 129 ++++++++++++
 tb/tb_store_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I store-path types: store funct3 encodings and the store FIFO entry.
package rv32i_types;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MBE_W = 4;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [XLEN-3:0]  word_addr;
    logic [XLEN-1:0]  wdata;
    logic [MBE_W-1:0] mbe;
  } store_entry_t;

endpackage

// File: rtl/store_aligner.sv
// Combinational store alignment: lane-replicates write data, builds the byte
// mask and flags misaligned or illegal stores.
module store_aligner
  import rv32i_types::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       byte_off,
  input  logic [XLEN-1:0]  data,
  output logic [XLEN-1:0]  wdata,
  output logic [MBE_W-1:0] mbe,
  output logic             fault
);

  always_comb begin
    wdata = '0;
    mbe   = '0;
    fault = 1'b0;
    case (store_funct3_t'(funct3))
      sb: begin
        wdata = {4{data[7:0]}};
        mbe   = MBE_W'(4'b0001 << byte_off);
      end
      sh: begin
        wdata = {2{data[15:0]}};
        if (byte_off[0]) fault = 1'b1;
        else             mbe   = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      sw: begin
        wdata = data;
        if (byte_off != 2'b00) fault = 1'b1;
        else                   mbe   = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the MEM stage and the data-cache write port,
// with misalignment faulting and word-granular load hazard detection.
module store_buffer
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_fault,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [DEPTH-1:0]   valid;
  store_entry_t       mem [DEPTH];

  logic [XLEN-1:0]    al_wdata;
  logic [MBE_W-1:0]   al_mbe;
  logic               al_fault;
  logic               push, pop;
  logic [1:0]         ld_addr_unused;

  store_aligner u_aligner (
    .funct3   (st_funct3),
    .byte_off (st_addr[1:0]),
    .data     (st_data),
    .wdata    (al_wdata),
    .mbe      (al_mbe),
    .fault    (al_fault)
  );

  assign ld_addr_unused = ld_addr[1:0];
  assign st_ready = (count < CNT_W'(DEPTH));
  assign st_fault = st_valid & al_fault;
  assign push     = st_valid & st_ready & ~al_fault;
  assign pop      = (state == WRITE) & dmem_resp;
  assign empty    = (count == '0) & (state == IDLE);

  // Entry storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{word_addr: st_addr[31:2], wdata: al_wdata, mbe: al_mbe};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        head        <= head + PTR_W'(1);
        valid[head] <= 1'b0;
      end
      if (push) begin
        tail        <= tail + PTR_W'(1);
        valid[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = WRITE;
      WRITE:   if (dmem_resp)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cache request registers: loaded from the head on entering WRITE, held until resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_write   <= 1'b0;
      dmem_address <= '0;
      dmem_wdata   <= '0;
      dmem_mbe     <= '0;
    end else if (state == IDLE && state_next == WRITE) begin
      dmem_write   <= 1'b1;
      dmem_address <= {mem[head].word_addr, 2'b00};
      dmem_wdata   <= mem[head].wdata;
      dmem_mbe     <= mem[head].mbe;
    end else if (pop) begin
      dmem_write   <= 1'b0;
      dmem_address <= '0;
      dmem_wdata   <= '0;
      dmem_mbe     <= '0;
    end
  end

  // Word-granular match against every pending entry, including the one in flight.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (mem[i].word_addr == ld_addr[31:2])) ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, drain ordering, faults, full
// handling, load hazards and mid-write reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_fault;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic        empty;

  int tests = 0;
  int fails = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_funct3    (st_funct3),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_fault     (st_fault),
    .ld_addr      (ld_addr),
    .ld_hazard    (ld_hazard),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_mbe     (dmem_mbe),
    .dmem_resp    (dmem_resp),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = v;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  // Waits (bounded) at negedges until a write request is visible.
  task automatic wait_write(output logic seen);
    seen = dmem_write;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1 seen = dmem_write;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    tests++; if (dmem_write !== 1'b0) begin fails++; $display("FAIL reset_write got=%b exp=0", dmem_write); end
    tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", st_ready); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL reset_hazard got=%b exp=0", ld_hazard); end
    tests++; if (st_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got=%b exp=0", st_fault); end
    tests++; if ({dmem_address, dmem_wdata, dmem_mbe} !== 68'h0) begin
      fails++; $display("FAIL reset_dmem got=%h/%h/%b exp=0", dmem_address, dmem_wdata, dmem_mbe); end
    rst = 1'b1;
  endtask

  task automatic test_sb();
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    #1;
    tests++; if (st_fault !== 1'b0 || st_ready !== 1'b1) begin
      fails++; $display("FAIL sb_accept fault=%b ready=%b exp 0/1", st_fault, st_ready); end
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    tests++; if (dmem_write !== 1'b0) begin fails++; $display("FAIL sb_lat1 got=%b exp=0", dmem_write); end
    @(negedge clk); #1;
    tests++; if (dmem_write !== 1'b1) begin fails++; $display("FAIL sb_lat2 got=%b exp=1", dmem_write); end
    tests++; if (dmem_address !== 32'h0000_1000 || dmem_wdata !== 32'hABAB_ABAB || dmem_mbe !== 4'b1000) begin
      fails++; $display("FAIL sb_data got=%h/%h/%b exp=00001000/abababab/1000", dmem_address, dmem_wdata, dmem_mbe); end
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    tests++; if (dmem_write !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL sb_done write=%b empty=%b exp 0/1", dmem_write, empty); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    tests++; if (dmem_write !== 1'b1 || dmem_address !== 32'h0000_2000 || dmem_wdata !== 32'h1234_1234 || dmem_mbe !== 4'b1100) begin
      fails++; $display("FAIL b2b_first got=%b %h/%h/%b exp 1 00002000/12341234/1100", dmem_write, dmem_address, dmem_wdata, dmem_mbe); end
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    tests++; if (dmem_write !== 1'b0 || empty !== 1'b0) begin
      fails++; $display("FAIL b2b_gap write=%b empty=%b exp 0/0", dmem_write, empty); end
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (dmem_write !== 1'b1 || dmem_address !== 32'h0000_3000 || dmem_wdata !== 32'hDEAD_BEEF || dmem_mbe !== 4'b1111) begin
        fails++; $display("FAIL b2b_second[%0d] got=%b %h/%h/%b exp 1 00003000/deadbeef/1111", k, dmem_write, dmem_address, dmem_wdata, dmem_mbe); end
      if (k == 2) dmem_resp = 1'b1;
      @(negedge clk); #1;
    end
    dmem_resp = 1'b0;
    tests++; if (dmem_write !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL b2b_done write=%b empty=%b exp 0/1", dmem_write, empty); end
  endtask

  task automatic test_faults();
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    f3[0] = 3'b001; ad[0] = 32'h0000_2001;
    f3[1] = 3'b010; ad[1] = 32'h0000_3002;
    f3[2] = 3'b011; ad[2] = 32'h0000_4000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, f3[k], ad[k], 32'h5555_5555);
      #1;
      tests++; if (st_fault !== 1'b1) begin fails++; $display("FAIL fault[%0d] got=%b exp=1", k, st_fault); end
    end
    @(negedge clk);
    drive(1'b0, 3'b011, 32'h0, 32'h0);
    #1;
    tests++; if (st_fault !== 1'b0) begin fails++; $display("FAIL fault_novalid got=%b exp=0", st_fault); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (empty !== 1'b1 || dmem_write !== 1'b0) begin
        fails++; $display("FAIL fault_noenq[%0d] empty=%b write=%b exp 1/0", k, empty, dmem_write); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_addr [4];
    logic seen;
    exp_addr[0] = 32'h0000_5004; exp_addr[1] = 32'h0000_5008;
    exp_addr[2] = 32'h0000_500C; exp_addr[3] = 32'h0000_6000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 3'b010, 32'h0000_5000 + 32'(4 * k), 32'(k));
      #1;
      tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL full_ready[%0d] got=%b exp=1", k, st_ready); end
    end
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL full_notready got=%b exp=0", st_ready); end
    tests++; if (dmem_write !== 1'b1 || dmem_address !== 32'h0000_5000) begin
      fails++; $display("FAIL full_head got=%b %h exp 1 00005000", dmem_write, dmem_address); end
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_6000, 32'h0000_0099);
    dmem_resp = 1'b1;
    #1;
    tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL full_pop_bypass got=%b exp=0", st_ready); end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL full_reopen got=%b exp=1", st_ready); end
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL full_refill got=%b exp=0", st_ready); end
    for (int k = 0; k < 4; k++) begin
      wait_write(seen);
      tests++; if (seen !== 1'b1 || dmem_address !== exp_addr[k]) begin
        fails++; $display("FAIL full_drain[%0d] write=%b addr=%h exp 1 %h", k, seen, dmem_address, exp_addr[k]); end
      dmem_resp = 1'b1;
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_empty got=%b exp=1", empty); end
  endtask

  task automatic test_hazard();
    logic seen;
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_4004, 32'h1111_2222);
    ld_addr = 32'h0000_4006;
    #1;
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_incoming got=%b exp=0", ld_hazard); end
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    tests++; if (ld_hazard !== 1'b1) begin fails++; $display("FAIL haz_pending got=%b exp=1", ld_hazard); end
    ld_addr = 32'h0000_4008;
    #1;
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_other got=%b exp=0", ld_hazard); end
    ld_addr = 32'h0000_4006;
    wait_write(seen);
    #1;
    tests++; if (seen !== 1'b1 || ld_hazard !== 1'b1) begin
      fails++; $display("FAIL haz_inflight write=%b haz=%b exp 1/1", seen, ld_hazard); end
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    tests++; if (ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_cleared got=%b exp=0", ld_hazard); end
    ld_addr = 32'h0;
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 3'b010, 32'h0000_7000 + 32'(4 * k), 32'hA5A5_0000 + 32'(k));
    end
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    wait_write(seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rstmid_pre write=%b exp=1", seen); end
    #2 rst = 1'b0;
    #1;
    tests++; if (dmem_write !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_async write=%b empty=%b ready=%b exp 0/1/1", dmem_write, empty, st_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      tests++; if (dmem_write !== 1'b0 || empty !== 1'b1) begin
        fails++; $display("FAIL rstmid_quiet[%0d] write=%b empty=%b exp 0/1", k, dmem_write, empty); end
    end
    drive(1'b1, 3'b000, 32'h0000_8001, 32'h0000_005A);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    wait_write(seen);
    tests++; if (seen !== 1'b1 || dmem_address !== 32'h0000_8000 || dmem_wdata !== 32'h5A5A_5A5A || dmem_mbe !== 4'b0010) begin
      fails++; $display("FAIL rstmid_new got=%b %h/%h/%b exp 1 00008000/5a5a5a5a/0010", seen, dmem_address, dmem_wdata, dmem_mbe); end
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
  endtask

  initial begin
    rst       = 1'b0;
    dmem_resp = 1'b0;
    ld_addr   = 32'h0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_sb();
    test_back_to_back();
    test_faults();
    test_full();
    test_hazard();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
